// File: rtl/nr_alu_issue_wb_if.sv
// Decoder, ALU and result-side signal bundle for the operand-issue / write-back stage.
// slave is the stage itself; master is the surrounding decoder, ALU and consumer.
interface nr_alu_issue_wb_if #(
    parameter int NREGS = 4,
    parameter int W     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_alo;
    logic [$clog2(NREGS)-1:0] in_ra;
    logic [$clog2(NREGS)-1:0] in_rb;
    logic                     in_use_imm;
    logic [W-1:0]             in_imm;
    logic [$clog2(NREGS)-1:0] in_rd;
    logic                     in_wen;

    logic [W-1:0]             alu_in0;
    logic [W-1:0]             alu_in1;
    logic [3:0]               alu_alo;
    logic [W-1:0]             alu_out0;
    logic                     alu_zero;
    logic [1:0]               alu_ovrflw;

    logic                     res_valid;
    logic                     res_ready;
    logic [W-1:0]             res_data;
    logic                     flag_zero;
    logic [1:0]               flag_ovf;
    logic [1:0]               ovf_sticky;
    logic                     clr_ovf;
    logic [7:0]               op_count;

    modport slave (
        input  in_valid, in_alo, in_ra, in_rb, in_use_imm, in_imm, in_rd, in_wen,
        output in_ready,
        output alu_in0, alu_in1, alu_alo,
        input  alu_out0, alu_zero, alu_ovrflw,
        output res_valid, res_data, flag_zero, flag_ovf, ovf_sticky, op_count,
        input  res_ready, clr_ovf
    );

    modport master (
        output in_valid, in_alo, in_ra, in_rb, in_use_imm, in_imm, in_rd, in_wen,
        input  in_ready,
        input  alu_in0, alu_in1, alu_alo,
        output alu_out0, alu_zero, alu_ovrflw,
        input  res_valid, res_data, flag_zero, flag_ovf, ovf_sticky, op_count,
        output res_ready, clr_ovf
    );
endinterface

// File: rtl/nr_alu_issue_wb.sv
// Operand-issue (E) and write-back (W) stage around a combinational 8-bit ALU.
// Owns the register file, forwards the in-flight result and counts completed ops.
module nr_alu_issue_wb #(
    parameter int NREGS = 4,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    nr_alu_issue_wb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [W-1:0]  r_rf [NREGS];
    logic          r_e_valid;
    logic          r_e_wen;
    logic [AW-1:0] r_e_rd;
    logic [W-1:0]  r_alu_in0;
    logic [W-1:0]  r_alu_in1;
    logic [3:0]    r_alu_alo;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic          r_flag_zero;
    logic [1:0]    r_flag_ovf;
    logic [1:0]    r_ovf_sticky;
    logic [7:0]    r_op_count;

    logic          w_stall;
    logic          w_accept;
    logic          w_complete;
    logic [W-1:0]  w_opa;
    logic [W-1:0]  w_opb;

    assign w_stall    = r_res_valid & ~bus.res_ready;
    assign w_accept   = bus.in_valid & ~w_stall;
    assign w_complete = r_e_valid & ~w_stall;

    // The E-stage result reaches the regfile on the same edge the new operands are
    // captured, so it must be bypassed from the ALU output instead of read from r_rf.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_opa = r_rf[bus.in_ra];
        w_opb = r_rf[bus.in_rb];
        if (r_e_valid && r_e_wen && (r_e_rd == bus.in_ra)) w_opa = bus.alu_out0;
        if (r_e_valid && r_e_wen && (r_e_rd == bus.in_rb)) w_opb = bus.alu_out0;
        if (bus.in_use_imm) w_opb = bus.in_imm;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the regfile is a handful of flops, so it is cleared with the rest of the state.
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
            r_e_valid    <= 1'b0;
            r_e_wen      <= 1'b0;
            r_e_rd       <= '0;
            r_alu_in0    <= '0;
            r_alu_in1    <= '0;
            r_alu_alo    <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_ovf   <= '0;
            r_ovf_sticky <= '0;
            r_op_count   <= '0;
        end else begin
            if (!w_stall) begin
                r_e_valid <= w_accept;
                if (w_accept) begin
                    r_alu_in0 <= w_opa;
                    r_alu_in1 <= w_opb;
                    r_alu_alo <= bus.in_alo;
                    r_e_rd    <= bus.in_rd;
                    r_e_wen   <= bus.in_wen;
                end
            end

            if (w_complete) begin
                r_res_valid <= 1'b1;
                r_res_data  <= bus.alu_out0;
                r_flag_zero <= bus.alu_zero;
                r_flag_ovf  <= bus.alu_ovrflw;
                r_op_count  <= r_op_count + 8'd1;
                if (r_e_wen) r_rf[r_e_rd] <= bus.alu_out0;
            end else if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            // A clear loses to an overflow completing on the same edge.
            r_ovf_sticky <= (bus.clr_ovf ? 2'b00 : r_ovf_sticky)
                          | (w_complete ? bus.alu_ovrflw : 2'b00);
        end
    end

    assign bus.in_ready   = ~w_stall;
    assign bus.alu_in0    = r_alu_in0;
    assign bus.alu_in1    = r_alu_in1;
    assign bus.alu_alo    = r_alu_alo;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.flag_zero  = r_flag_zero;
    assign bus.flag_ovf   = r_flag_ovf;
    assign bus.ovf_sticky = r_ovf_sticky;
    assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_nr_alu_issue_wb.sv
// Self-checking bench for nr_alu_issue_wb: directed scenarios plus a randomized run
// scored against an in-order architectural model of the register file.
module tb_nr_alu_issue_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic [1:0] o;
    } exp_t;

    nr_alu_issue_wb_if bus ();
    nr_alu_issue_wb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Stand-in ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 lt, 7 sl, 8 sr, others pass a.
    function automatic exp_t alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        r.d = a;
        r.o = 2'b00;
        case (op)
            4'd0: begin
                r.d = a + b;
                if (!a[7] && !b[7] && r.d[7]) r.o = 2'b01;
                else if (a[7] && b[7] && !r.d[7]) r.o = 2'b10;
            end
            4'd1: begin
                r.d = a - b;
                if (!a[7] && b[7] && r.d[7]) r.o = 2'b01;
                else if (a[7] && !b[7] && !r.d[7]) r.o = 2'b10;
            end
            4'd2: r.d = a & b;
            4'd3: r.d = a | b;
            4'd4: r.d = a ^ b;
            4'd5: r.d = ~a;
            4'd6: r.d = (a < b) ? 8'd1 : 8'd0;
            4'd7: r.d = a << b[2:0];
            4'd8: r.d = a >> b[2:0];
            default: r.d = a;
        endcase
        r.z = (r.d == 8'd0);
        return r;
    endfunction

    exp_t alu_now;
    assign alu_now        = alu_f(bus.alu_alo, bus.alu_in0, bus.alu_in1);
    assign bus.alu_out0   = alu_now.d;
    assign bus.alu_zero   = alu_now.z;
    assign bus.alu_ovrflw = alu_now.o;

    task automatic set_op(input logic [3:0] alo, input logic [1:0] ra, input logic [1:0] rb,
                          input logic ui, input logic [7:0] imm, input logic [1:0] rd, input logic wen);
        bus.in_valid   = 1'b1;
        bus.in_alo     = alo;
        bus.in_ra      = ra;
        bus.in_rb      = rb;
        bus.in_use_imm = ui;
        bus.in_imm     = imm;
        bus.in_rd      = rd;
        bus.in_wen     = wen;
    endtask

    task automatic clr_in();
        set_op(4'd0, 2'd0, 2'd0, 1'b0, 8'd0, 2'd0, 1'b0);
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        bus.res_ready = 1'b1;
        bus.clr_ovf   = 1'b0;
        @(posedge clk);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        n_checks++; if (bus.op_count !== 8'd0) begin n_fail++; $display("FAIL rst_op_count: got %h want 00", bus.op_count); end
        n_checks++; if ({bus.alu_in0, bus.alu_in1, bus.alu_alo} !== 20'd0) begin n_fail++; $display("FAIL rst_alu_in: got %h %h %h want 0", bus.alu_in0, bus.alu_in1, bus.alu_alo); end
        n_checks++; if ({bus.res_data, bus.flag_zero, bus.flag_ovf, bus.ovf_sticky} !== 13'd0) begin n_fail++; $display("FAIL rst_flags: got %h %b %b %b want 0", bus.res_data, bus.flag_zero, bus.flag_ovf, bus.ovf_sticky); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        // Accept r1 = r0 + 7, then reset before it can complete.
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'd7, 2'd1, 1'b1);
        step();
        clr_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.res_valid !== 1'b0 || bus.op_count !== 8'd0) begin n_fail++; $display("FAIL midop_reset: got valid=%b cnt=%h want 0 00", bus.res_valid, bus.op_count); end
        n_checks++; if (bus.alu_in1 !== 8'd0 || bus.res_data !== 8'd0) begin n_fail++; $display("FAIL midop_regs: got in1=%h data=%h want 00 00", bus.alu_in1, bus.res_data); end
        set_op(4'd0, 2'd1, 2'd1, 1'b0, 8'd0, 2'd0, 1'b0);
        step();
        clr_in();
        n_checks++; if (bus.alu_in0 !== 8'd0) begin n_fail++; $display("FAIL midop_rf_unchanged: got r1=%h want 00", bus.alu_in0); end
        step();
    endtask

    task automatic test_forwarding();
        do_reset();
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'd5, 2'd1, 1'b1);
        step();
        set_op(4'd0, 2'd1, 2'd1, 1'b0, 8'd0, 2'd2, 1'b1);
        step();
        clr_in();
        n_checks++; if (bus.alu_in0 !== 8'd5 || bus.alu_in1 !== 8'd5) begin n_fail++; $display("FAIL fwd_operands: got %h %h want 05 05", bus.alu_in0, bus.alu_in1); end
        n_checks++; if (bus.res_data !== 8'd5 || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_first_result: got %h v=%b want 05 v=1", bus.res_data, bus.res_valid); end
        step();
        n_checks++; if (bus.res_data !== 8'd10) begin n_fail++; $display("FAIL fwd_sum: got %h want 0a", bus.res_data); end
        set_op(4'd0, 2'd2, 2'd0, 1'b1, 8'd0, 2'd3, 1'b0);
        step();
        clr_in();
        n_checks++; if (bus.alu_in0 !== 8'd10) begin n_fail++; $display("FAIL fwd_rf2: got %h want 0a", bus.alu_in0); end
        step();
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'd5, 2'd1, 1'b1);   // r1 = 5
        step();
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'd10, 2'd2, 1'b1);  // r2 = 10
        step();
        clr_in();
        step();
        step();
        bus.res_ready = 1'b0;
        set_op(4'd0, 2'd1, 2'd0, 1'b1, 8'd1, 2'd0, 1'b1);   // A: r0 = r1 + 1 = 6
        step();
        set_op(4'd0, 2'd0, 2'd2, 1'b0, 8'd0, 2'd3, 1'b1);   // B: r3 = r0 + r2 = 16
        step();
        set_op(4'd1, 2'd3, 2'd1, 1'b0, 8'd0, 2'd1, 1'b1);   // C: r1 = r3 - r1 = 11
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            n_checks++; if (bus.alu_in0 !== 8'd6 || bus.alu_in1 !== 8'd10) begin n_fail++; $display("FAIL bp_held_operands[%0d]: got %h %h want 06 0a", i, bus.alu_in0, bus.alu_in1); end
            n_checks++; if (bus.op_count !== 8'd3 || bus.res_data !== 8'd6) begin n_fail++; $display("FAIL bp_held_result[%0d]: got cnt=%h data=%h want 03 06", i, bus.op_count, bus.res_data); end
            step();
        end
        bus.res_ready = 1'b1;
        step();
        clr_in();
        n_checks++; if (bus.res_data !== 8'd16 || bus.alu_in0 !== 8'd16 || bus.alu_in1 !== 8'd5) begin n_fail++; $display("FAIL bp_release_b: got data=%h in=%h %h want 10 10 05", bus.res_data, bus.alu_in0, bus.alu_in1); end
        step();
        n_checks++; if (bus.res_data !== 8'd11 || bus.op_count !== 8'd5) begin n_fail++; $display("FAIL bp_release_c: got data=%h cnt=%h want 0b 05", bus.res_data, bus.op_count); end
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 2'd1, 1'b1);
        step();
        set_op(4'd0, 2'd1, 2'd0, 1'b1, 8'h01, 2'd2, 1'b0);
        step();
        clr_in();
        step();
        n_checks++; if (bus.res_data !== 8'h80 || bus.flag_ovf !== 2'b01 || bus.ovf_sticky !== 2'b01) begin n_fail++; $display("FAIL ovf_pos: got %h ovf=%b sticky=%b want 80 01 01", bus.res_data, bus.flag_ovf, bus.ovf_sticky); end
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        n_checks++; if (bus.ovf_sticky !== 2'b00 || bus.flag_ovf !== 2'b01) begin n_fail++; $display("FAIL ovf_clear: got sticky=%b flag=%b want 00 01", bus.ovf_sticky, bus.flag_ovf); end
        set_op(4'd0, 2'd1, 2'd0, 1'b1, 8'h01, 2'd2, 1'b0);
        step();
        clr_in();
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        n_checks++; if (bus.ovf_sticky !== 2'b01) begin n_fail++; $display("FAIL ovf_clear_and_set: got %b want 01", bus.ovf_sticky); end
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'h80, 2'd3, 1'b1);   // r3 = 0x80
        step();
        set_op(4'd0, 2'd3, 2'd3, 1'b0, 8'h00, 2'd0, 1'b0);   // 0x80 + 0x80
        step();
        clr_in();
        step();
        n_checks++; if (bus.res_data !== 8'h00 || bus.flag_zero !== 1'b1 || bus.flag_ovf !== 2'b10 || bus.ovf_sticky !== 2'b11) begin n_fail++; $display("FAIL ovf_neg: got %h z=%b ovf=%b sticky=%b want 00 1 10 11", bus.res_data, bus.flag_zero, bus.flag_ovf, bus.ovf_sticky); end
    endtask

    task automatic test_counter_wrap();
        int drops = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            set_op(4'($urandom_range(0, 8)), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
            step();
            if (i >= 1 && bus.res_valid !== 1'b1) drops++;
            if (i == 255) begin
                n_checks++; if (bus.op_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %h want ff", bus.op_count); end
            end
        end
        clr_in();
        step();
        n_checks++; if (bus.op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %h want 00", bus.op_count); end
        n_checks++; if (drops !== 0 || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got drops=%0d valid=%b want 0 1", drops, bus.res_valid); end
        step();
    endtask

    task automatic test_no_write();
        do_reset();
        set_op(4'd0, 2'd0, 2'd0, 1'b1, 8'h44, 2'd3, 1'b1);
        step();
        clr_in();
        step();
        set_op(4'd4, 2'd3, 2'd0, 1'b1, 8'hFF, 2'd3, 1'b0);   // r3 ^ 0xFF, not written
        step();
        set_op(4'd0, 2'd3, 2'd0, 1'b1, 8'h00, 2'd0, 1'b0);   // read r3 back-to-back
        step();
        clr_in();
        n_checks++; if (bus.alu_in0 !== 8'h44) begin n_fail++; $display("FAIL nowr_r3: got %h want 44", bus.alu_in0); end
        n_checks++; if (bus.res_data !== 8'hBB) begin n_fail++; $display("FAIL nowr_result: got %h want bb", bus.res_data); end
        step();
        step();
    endtask

    task automatic test_random();
        logic [7:0] m_rf [4];
        exp_t       q[$];
        exp_t       e;
        int         m_done = 0;
        bit         pend = 1'b0;
        logic [7:0] pa, pb, a, b;
        logic [3:0] palo, alo;
        logic [1:0] ra, rb, rd;
        logic       ui, wen;
        logic [7:0] imm;
        do_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (pend) begin
                pend = 1'b0;
                n_checks++; if (bus.alu_in0 !== pa || bus.alu_in1 !== pb || bus.alu_alo !== palo) begin n_fail++; $display("FAIL rnd_operands@%0d: got %h %h %h want %h %h %h", cyc, bus.alu_in0, bus.alu_in1, bus.alu_alo, pa, pb, palo); end
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            clr_in();
            if (cyc < 400 && $urandom_range(0, 3) != 0) begin
                alo = 4'($urandom_range(0, 10)); ra = 2'($urandom); rb = 2'($urandom); rd = 2'($urandom);
                ui = 1'($urandom); wen = ($urandom_range(0, 3) != 0); imm = 8'($urandom);
                set_op(alo, ra, rb, ui, imm, rd, wen);
            end
            #1;
            n_checks++; if (bus.in_ready !== !(bus.res_valid && !bus.res_ready)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b valid=%b ready=%b", cyc, bus.in_ready, bus.res_valid, bus.res_ready); end
            if (bus.res_valid === 1'b1 && bus.res_ready) begin
                m_done++;
                if (q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL rnd_unexpected_result@%0d: got %h want none", cyc, bus.res_data);
                end else begin
                    e = q.pop_front();
                    n_checks++; if (bus.res_data !== e.d || bus.flag_zero !== e.z || bus.flag_ovf !== e.o) begin n_fail++; $display("FAIL rnd_result@%0d: got %h z=%b o=%b want %h z=%b o=%b", cyc, bus.res_data, bus.flag_zero, bus.flag_ovf, e.d, e.z, e.o); end
                    n_checks++; if (bus.op_count !== 8'(m_done)) begin n_fail++; $display("FAIL rnd_op_count@%0d: got %h want %h", cyc, bus.op_count, 8'(m_done)); end
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                a = m_rf[bus.in_ra];
                b = bus.in_use_imm ? bus.in_imm : m_rf[bus.in_rb];
                e = alu_f(bus.in_alo, a, b);
                if (bus.in_wen) m_rf[bus.in_rd] = e.d;
                q.push_back(e);
                pa = a; pb = b; palo = bus.in_alo; pend = 1'b1;
            end
            @(negedge clk);
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d results left want 0", q.size()); end
    endtask

    initial begin
        clr_in();
        bus.res_ready = 1'b1;
        bus.clr_ovf   = 1'b0;
        test_reset();
        test_forwarding();
        test_backpressure();
        test_overflow();
        test_counter_wrap();
        test_no_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
